// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared types and helpers for the router packet transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_MAX = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HEADER     = 3'd1,
        ST_PAYLOAD    = 3'd2,
        ST_PARITY     = 3'd3,
        ST_WAIT_ACK   = 3'd4,
        ST_SAMPLE_ERR = 3'd5
    } tx_state_t;

    // Header byte: payload length in the upper bits, destination in the lower two.
    function automatic logic [BYTE_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_tx_lfsr.sv
// ============================================================================
// Module      : router_tx_lfsr
// Description : 8-bit Galois LFSR payload generator with load/advance control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module router_tx_lfsr
    import router_pkg::*;
#(
    parameter logic [BYTE_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              advance,
    output logic [BYTE_W-1:0] value,
    output logic [BYTE_W-1:0] next_value
);

    always_comb begin
        next_value = (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end

    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
        end else if (load) begin
            value <= (seed == '0) ? 8'h01 : seed;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

`default_nettype wire

// File: rtl/router_pkt_tx.sv
// ============================================================================
// Module      : router_pkt_tx
// Description : Router input-port packet source (header, LFSR payload, parity)
//               with busy flow control, ack wait and busy timeout.
//               Optional macro ROUTER_TX_PARITY_CORRUPT_EN adds corrupt_parity.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module router_pkt_tx
    import router_pkg::*;
#(
    parameter logic [BYTE_W-1:0] LFSR_TAPS    = 8'hB8,
    parameter int                BUSY_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic [BYTE_W-1:0] seed,
    input  logic              busy_in,
    input  logic              err_in,
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    input  logic              corrupt_parity,
`endif
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              tx_busy,
    output logic              done,
    output logic              pkt_err,
    output logic              cfg_err,
    output logic              timeout
);

    localparam int              CNT_W      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    tx_state_t         r_state;
    logic [LEN_W-1:0]  r_remain;
    logic [BYTE_W-1:0] r_parity;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic              w_legal;
    logic              w_active;
    logic              w_timeout_hit;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic [BYTE_W-1:0] w_lfsr_val;
    logic [BYTE_W-1:0] w_lfsr_next;
    logic [BYTE_W-1:0] w_par_next;
    logic [BYTE_W-1:0] w_par_out;

    assign w_legal       = (dest_addr <= ADDR_MAX) && (pay_len != '0);
    assign w_active      = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) ||
                           (r_state == ST_PARITY) || (r_state == ST_WAIT_ACK);
    assign w_timeout_hit = w_active && busy_in && (r_busy_cnt == C_CNT_LAST);
    assign w_lfsr_load   = (r_state == ST_IDLE) && start && w_legal;
    assign w_lfsr_adv    = (r_state == ST_PAYLOAD) && !busy_in;
    assign w_par_next    = r_parity ^ w_lfsr_val;

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    logic r_corrupt;
    assign w_par_out = r_corrupt ? ~w_par_next : w_par_next;
`else
    assign w_par_out = w_par_next;
`endif

    router_tx_lfsr #(
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clock      (clock),
        .resetn     (resetn),
        .load       (w_lfsr_load),
        .seed       (seed),
        .advance    (w_lfsr_adv),
        .value      (w_lfsr_val),
        .next_value (w_lfsr_next)
    );

    // All outputs are registered; a byte leaves data_out only on an edge with busy_in low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_remain   <= '0;
            r_parity   <= '0;
            r_busy_cnt <= '0;
            pkt_valid  <= 1'b0;
            data_out   <= '0;
            tx_busy    <= 1'b0;
            done       <= 1'b0;
            pkt_err    <= 1'b0;
            cfg_err    <= 1'b0;
            timeout    <= 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
            r_corrupt  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            timeout <= 1'b0;

            if (w_active && busy_in) begin
                r_busy_cnt <= r_busy_cnt + CNT_W'(1);
            end else begin
                r_busy_cnt <= '0;
            end

            if (w_timeout_hit) begin
                r_state    <= ST_IDLE;
                r_busy_cnt <= '0;
                pkt_valid  <= 1'b0;
                tx_busy    <= 1'b0;
                done       <= 1'b1;
                timeout    <= 1'b1;
                pkt_err    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (w_legal) begin
                                r_state   <= ST_HEADER;
                                r_remain  <= pay_len;
                                pkt_valid <= 1'b1;
                                data_out  <= pack_header(pay_len, dest_addr);
                                tx_busy   <= 1'b1;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
                                r_corrupt <= corrupt_parity;
`endif
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_HEADER: begin
                        if (!busy_in) begin
                            r_parity <= data_out;
                            data_out <= w_lfsr_val;
                            r_state  <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (!busy_in) begin
                            r_parity <= w_par_next;
                            r_remain <= r_remain - LEN_W'(1);
                            if (r_remain == LEN_W'(1)) begin
                                r_state   <= ST_PARITY;
                                pkt_valid <= 1'b0;
                                data_out  <= w_par_out;
                            end else begin
                                data_out <= w_lfsr_next;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (!busy_in) begin
                            r_state <= ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (!busy_in) begin
                            r_state <= ST_SAMPLE_ERR;
                        end
                    end
                    ST_SAMPLE_ERR: begin
                        pkt_err <= err_in;
                        done    <= 1'b1;
                        tx_busy <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
